// File: rtl/gui_pkg.sv
// Shared definitions for the GUI sprite path: display geometry, sprite
// selector encodings and the fighter animation state type.
package gui_pkg;

  localparam int unsigned OLED_W      = 96;
  localparam int unsigned OLED_H      = 64;
  localparam int unsigned OLED_PIXELS = OLED_W * OLED_H;

  localparam logic [2:0] SPR_IDLE   = 3'd0;
  localparam logic [2:0] SPR_PUNCH1 = 3'd1;
  localparam logic [2:0] SPR_PUNCH2 = 3'd2;
  localparam logic [2:0] SPR_KICK1  = 3'd3;
  localparam logic [2:0] SPR_KICK2  = 3'd4;
  localparam logic [2:0] SPR_BLOCK  = 3'd5;
  localparam logic [2:0] SPR_HURT   = 3'd6;

  typedef enum logic [3:0] {
    StIdle,
    StPWind,
    StPHit,
    StPRec,
    StKWind,
    StKHit,
    StKRec,
    StBlock,
    StHurt
  } anim_state_e;

  function automatic logic [2:0] state_sprite(anim_state_e s);
    case (s)
      StPWind, StPRec: return SPR_PUNCH1;
      StPHit:          return SPR_PUNCH2;
      StKWind, StKRec: return SPR_KICK1;
      StKHit:          return SPR_KICK2;
      StBlock:         return SPR_BLOCK;
      StHurt:          return SPR_HURT;
      default:         return SPR_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/gui_anim_sequencer_if.sv
// Control/status bundle between game logic (master) and one fighter's
// animation sequencer (slave).
interface gui_anim_sequencer_if;

  logic        frame_tick;
  logic        punch_req;
  logic        kick_req;
  logic        block_hold;
  logic        hit_in;
  logic        facing_left;
  logic [12:0] pixel_index;
  logic [2:0]  sprite_sel;
  logic        attack_active;
  logic        busy;
  logic [12:0] rom_pixel_index;

  modport master (
    output frame_tick, punch_req, kick_req, block_hold, hit_in, facing_left, pixel_index,
    input  sprite_sel, attack_active, busy, rom_pixel_index
  );

  modport slave (
    input  frame_tick, punch_req, kick_req, block_hold, hit_in, facing_left, pixel_index,
    output sprite_sel, attack_active, busy, rom_pixel_index
  );

endinterface

// File: rtl/gui_pixel_mirror.sv
// Registered raster-index remap: splits the index into row/col and mirrors
// the column when the sprite faces left. Out-of-frame indices pass through.
module gui_pixel_mirror
  import gui_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        facing_left,
  input  logic [12:0] pixel_index,
  output logic [12:0] rom_pixel_index
);

  logic [12:0] col;
  logic [12:0] row;
  logic [12:0] remap_d;

  always_comb begin
    col     = pixel_index % 13'(OLED_W);
    row     = pixel_index / 13'(OLED_W);
    remap_d = pixel_index;
    if (pixel_index < 13'(OLED_PIXELS) && facing_left) begin
      remap_d = row * 13'(OLED_W) + (13'(OLED_W - 1) - col);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_pixel_index <= '0;
    end else begin
      rom_pixel_index <= remap_d;
    end
  end

endmodule

// File: rtl/gui_anim_sequencer.sv
// Per-fighter animation sequencer: turns action requests into timed sprite
// frames and an attack window; also remaps the pixel index for the ROMs.
module gui_anim_sequencer
  import gui_pkg::*;
#(
  parameter int unsigned WIND_TICKS = 2,
  parameter int unsigned HIT_TICKS  = 3,
  parameter int unsigned STUN_TICKS = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gui_anim_sequencer_if.slave  bus
);

  localparam logic [3:0] WIND_LD = 4'(WIND_TICKS);
  localparam logic [3:0] HIT_LD  = 4'(HIT_TICKS);
  localparam logic [3:0] STUN_LD = 4'(STUN_TICKS);

  anim_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        punch_q, kick_q;
  logic        punch_pend_q, punch_pend_d;
  logic        kick_pend_q, kick_pend_d;
  logic        hit_pend_q, hit_pend_d;
  logic        punch_avail, kick_avail, hit_avail;
  logic        last, stay_open;
  logic [3:0]  cnt_dec;

  always_comb begin
    punch_avail = punch_pend_q | (bus.punch_req & ~punch_q);
    kick_avail  = kick_pend_q | (bus.kick_req & ~kick_q);
    hit_avail   = hit_pend_q | bus.hit_in;
    last        = (cnt_q == 4'd1);
    cnt_dec     = cnt_q - 4'd1;
    state_d     = state_q;
    cnt_d       = cnt_q;

    if (bus.frame_tick) begin
      if (hit_avail && state_q != StBlock) begin
        state_d = StHurt;
        cnt_d   = STUN_LD;
      end else begin
        case (state_q)
          StIdle: begin
            if (bus.block_hold) begin
              state_d = StBlock;
            end else if (punch_avail) begin
              state_d = StPWind;
              cnt_d   = WIND_LD;
            end else if (kick_avail) begin
              state_d = StKWind;
              cnt_d   = WIND_LD;
            end
          end
          StBlock: if (!bus.block_hold) state_d = StIdle;
          StPWind: if (last) begin state_d = StPHit;  cnt_d = HIT_LD;  end else cnt_d = cnt_dec;
          StPHit:  if (last) begin state_d = StPRec;  cnt_d = WIND_LD; end else cnt_d = cnt_dec;
          StPRec:  if (last) begin state_d = StIdle;  cnt_d = '0;      end else cnt_d = cnt_dec;
          StKWind: if (last) begin state_d = StKHit;  cnt_d = HIT_LD;  end else cnt_d = cnt_dec;
          StKHit:  if (last) begin state_d = StKRec;  cnt_d = WIND_LD; end else cnt_d = cnt_dec;
          StKRec:  if (last) begin state_d = StIdle;  cnt_d = '0;      end else cnt_d = cnt_dec;
          StHurt:  if (last) begin state_d = StIdle;  cnt_d = '0;      end else cnt_d = cnt_dec;
          default: begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        endcase
      end
    end

    // Requests only survive while the fighter can act on them; anything seen
    // during a sequence or a stun is dropped rather than queued.
    stay_open    = (state_d == StIdle) || (state_d == StBlock);
    punch_pend_d = stay_open & punch_avail;
    kick_pend_d  = stay_open & kick_avail;
    hit_pend_d   = bus.frame_tick ? 1'b0 : hit_avail;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= StIdle;
      cnt_q             <= '0;
      punch_q           <= 1'b0;
      kick_q            <= 1'b0;
      punch_pend_q      <= 1'b0;
      kick_pend_q       <= 1'b0;
      hit_pend_q        <= 1'b0;
      bus.sprite_sel    <= SPR_IDLE;
      bus.attack_active <= 1'b0;
      bus.busy          <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      punch_q           <= bus.punch_req;
      kick_q            <= bus.kick_req;
      punch_pend_q      <= punch_pend_d;
      kick_pend_q       <= kick_pend_d;
      hit_pend_q        <= hit_pend_d;
      bus.sprite_sel    <= state_sprite(state_d);
      bus.attack_active <= (state_d == StPHit) || (state_d == StKHit);
      bus.busy          <= !((state_d == StIdle) || (state_d == StBlock));
    end
  end

  gui_pixel_mirror u_mirror (
    .clk             (clk),
    .rst_n           (rst_n),
    .facing_left     (bus.facing_left),
    .pixel_index     (bus.pixel_index),
    .rom_pixel_index (bus.rom_pixel_index)
  );

endmodule

// File: tb/tb_gui_anim_sequencer.sv
// Directed bench for gui_anim_sequencer: punch/kick/block/hurt sequences,
// pixel mirroring and asynchronous reset mid-sequence.
module tb_gui_anim_sequencer;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  gui_anim_sequencer_if bus ();

  gui_anim_sequencer #(
    .WIND_TICKS (2),
    .HIT_TICKS  (3),
    .STUN_TICKS (6)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_fsm(input string tag, input int spr, input bit att, input bit bsy);
    chk({tag, ".sprite"}, 16'(bus.sprite_sel), 16'(spr));
    chk({tag, ".attack"}, 16'(bus.attack_active), 16'(att));
    chk({tag, ".busy"}, 16'(bus.busy), 16'(bsy));
  endtask

  task automatic tick();
    @(negedge clk);
    bus.frame_tick = 1'b1;
    @(posedge clk);
    #1 bus.frame_tick = 1'b0;
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic hit_pulse();
    bus.hit_in = 1'b1;
    clk1();
    bus.hit_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pseq[8];
    bus.frame_tick  = 1'b0;
    bus.punch_req   = 1'b0;
    bus.kick_req    = 1'b0;
    bus.block_hold  = 1'b0;
    bus.hit_in      = 1'b0;
    bus.facing_left = 1'b0;
    bus.pixel_index = 13'd0;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk_fsm("reset", 0, 1'b0, 1'b0);
    chk("reset.rom", 16'(bus.rom_pixel_index), 16'd0);
    repeat (2) clk1();
    @(negedge clk) rst_n = 1'b1;
    clk1();

    // Punch: 1,1,2,2,2,1,1 then idle
    pseq = '{1, 1, 2, 2, 2, 1, 1, 0};
    bus.punch_req = 1'b1;
    clk1();
    foreach (pseq[i]) begin
      tick();
      chk_fsm($sformatf("punch[%0d]", i), pseq[i], pseq[i] == 2, pseq[i] != 0);
    end
    bus.punch_req = 1'b0;
    clk1();

    // Kick held high; punch edge during K_HIT is dropped
    bus.kick_req = 1'b1;
    clk1();
    tick(); chk_fsm("kick0", 3, 1'b0, 1'b1);
    tick(); chk_fsm("kick1", 3, 1'b0, 1'b1);
    tick(); chk_fsm("kick2", 4, 1'b1, 1'b1);
    bus.punch_req = 1'b1;
    clk1();
    tick(); chk_fsm("kick3", 4, 1'b1, 1'b1);
    tick(); chk_fsm("kick4", 4, 1'b1, 1'b1);
    tick(); chk_fsm("kick5", 3, 1'b0, 1'b1);
    tick(); chk_fsm("kick6", 3, 1'b0, 1'b1);
    tick(); chk_fsm("kick7", 0, 1'b0, 1'b0);
    tick(); chk_fsm("no_punch", 0, 1'b0, 1'b0);

    // Fresh punch edge starts P_WIND
    bus.punch_req = 1'b0;
    clk1();
    bus.punch_req = 1'b1;
    clk1();
    bus.kick_req = 1'b0;
    tick(); chk_fsm("fresh_punch0", 1, 1'b0, 1'b1);
    tick(); chk_fsm("fresh_punch1", 1, 1'b0, 1'b1);
    tick(); chk_fsm("fresh_punch2", 2, 1'b1, 1'b1);

    // Hit during P_HIT, then re-stun after 3 HURT ticks
    bus.punch_req = 1'b0;
    hit_pulse();
    tick(); chk_fsm("hurt0", 6, 1'b0, 1'b1);
    tick(); chk_fsm("hurt1", 6, 1'b0, 1'b1);
    tick(); chk_fsm("hurt2", 6, 1'b0, 1'b1);
    hit_pulse();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_fsm($sformatf("restun[%0d]", i), 6, 1'b0, 1'b1);
    end
    tick(); chk_fsm("restun_end", 0, 1'b0, 1'b0);

    // Block absorbs hits
    bus.block_hold = 1'b1;
    tick(); chk_fsm("block0", 5, 1'b0, 1'b0);
    hit_pulse();
    tick(); chk_fsm("block_hit", 5, 1'b0, 1'b0);
    tick(); chk_fsm("block2", 5, 1'b0, 1'b0);
    bus.block_hold = 1'b0;
    tick(); chk_fsm("block_rel", 0, 1'b0, 1'b0);
    tick(); chk_fsm("block_after", 0, 1'b0, 1'b0);

    // Pixel mirror
    bus.facing_left = 1'b1; bus.pixel_index = 13'd1773;
    clk1(); chk("pix_left_1773", 16'(bus.rom_pixel_index), 16'd1778);
    bus.facing_left = 1'b0;
    clk1(); chk("pix_right_1773", 16'(bus.rom_pixel_index), 16'd1773);
    bus.facing_left = 1'b1; bus.pixel_index = 13'd0;
    clk1(); chk("pix_left_0", 16'(bus.rom_pixel_index), 16'd95);
    bus.pixel_index = 13'd6143;
    clk1(); chk("pix_left_6143", 16'(bus.rom_pixel_index), 16'd6048);
    bus.pixel_index = 13'd6200;
    clk1(); chk("pix_oob", 16'(bus.rom_pixel_index), 16'd6200);
    bus.facing_left = 1'b0; bus.pixel_index = 13'd100;
    clk1(); chk("pix_right_100", 16'(bus.rom_pixel_index), 16'd100);

    // Async reset during K_HIT with a hit pending
    bus.kick_req = 1'b0;
    clk1();
    bus.kick_req = 1'b1;
    clk1();
    tick(); tick(); tick();
    chk_fsm("rst_pre", 4, 1'b1, 1'b1);
    hit_pulse();
    #2 rst_n = 1'b0;
    #1;
    chk_fsm("rst_mid", 0, 1'b0, 1'b0);
    chk("rst_mid.rom", 16'(bus.rom_pixel_index), 16'd0);
    bus.kick_req = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick(); chk_fsm("rst_after0", 0, 1'b0, 1'b0);
    tick(); chk_fsm("rst_after1", 0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
